// File: rtl/sram_arbiter_ctrl.sv
// Two-port arbiter and sequencer for an async SRAM; all SRAM-side outputs are registered.
// Define SRAM_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round robin.
module sram_arbiter_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 18,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned RD_WAIT_CYCLES  = 2,
    parameter int unsigned WR_PULSE_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  resetb_i,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  ack0_o,
    output logic                  ack1_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic                  busy_o,
    output logic                  sram_ceb_o,
    output logic                  sram_web_o,
    output logic                  sram_oeb_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_dout_o,
    output logic                  sram_doe_o,
    input  logic [DATA_WIDTH-1:0] sram_din_i
);

    localparam logic [7:0] RdLast = 8'(RD_WAIT_CYCLES - 1);
    localparam logic [7:0] WrLast = 8'(WR_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRdWait,
        StRdCapt
    } state_e;

    state_e                state_q;
    logic [7:0]            cnt_q;
    logic                  port_q;
    logic                  ceb_q, web_q, oeb_q, doe_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid0_q, rvalid1_q;
`ifdef SRAM_ARB_FIXED_PRIO_EN
`else
    logic                  last_grant_q;
`endif

    logic                  gnt0, gnt1;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Grant is combinational so ack lands in the IDLE cycle; held low while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle && resetb_i) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            gnt0 = req0_i;
            gnt1 = req1_i && !req0_i;
`else
            if (req0_i && req1_i) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0_i;
                gnt1 = req1_i;
            end
`endif
        end
    end

    always_comb begin
        sel_we    = gnt1 ? we1_i    : we0_i;
        sel_addr  = gnt1 ? addr1_i  : addr0_i;
        sel_wdata = gnt1 ? wdata1_i : wdata0_i;
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            port_q    <= 1'b0;
            ceb_q     <= 1'b1;
            web_q     <= 1'b1;
            oeb_q     <= 1'b1;
            doe_q     <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
`else
            last_grant_q <= 1'b1;
`endif
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        port_q <= gnt1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
`else
                        last_grant_q <= gnt1;
`endif
                        addr_q <= sel_addr;
                        ceb_q  <= 1'b0;
                        cnt_q  <= '0;
                        if (sel_we) begin
                            dout_q  <= sel_wdata;
                            doe_q   <= 1'b1;
                            state_q <= StWrSetup;
                        end else begin
                            oeb_q   <= 1'b0;
                            state_q <= StRdWait;
                        end
                    end
                end
                StWrSetup: begin
                    web_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= StWrPulse;
                end
                StWrPulse: begin
                    if (cnt_q == WrLast) begin
                        web_q   <= 1'b1;
                        state_q <= StWrHold;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StWrHold: begin
                    ceb_q   <= 1'b1;
                    doe_q   <= 1'b0;
                    state_q <= StIdle;
                end
                StRdWait: begin
                    if (cnt_q == RdLast) begin
                        rdata_q   <= sram_din_i;
                        ceb_q     <= 1'b1;
                        oeb_q     <= 1'b1;
                        rvalid0_q <= !port_q;
                        rvalid1_q <= port_q;
                        state_q   <= StRdCapt;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StRdCapt: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack0_o      = gnt0;
    assign ack1_o      = gnt1;
    assign busy_o      = (state_q != StIdle);
    assign rdata_o     = rdata_q;
    assign rvalid0_o   = rvalid0_q;
    assign rvalid1_o   = rvalid1_q;
    assign sram_ceb_o  = ceb_q;
    assign sram_web_o  = web_q;
    assign sram_oeb_o  = oeb_q;
    assign sram_addr_o = addr_q;
    assign sram_dout_o = dout_q;
    assign sram_doe_o  = doe_q;

endmodule
